// File: rtl/io_poll_master.sv
// Round-robin poller of I/O control words; raises irq when ready (bit 0) and IE (bit 8) are both set.
// Latency: capture on the first granted RD edge, irq two edges after grant; optional write-back under IO_POLL_AUTOCLEAR_EN.
// Backpressure: holds busReq in RD/WR until busGnt; one granted cycle per access; irq held until irqAck.
module io_poll_master #(
    parameter int          NDEV     = 3,
    parameter logic [31:0] ADDR0    = 32'hF0000120,
    parameter logic [31:0] ADDR1    = 32'hF0000104,
    parameter logic [31:0] ADDR2    = 32'hF0000114,
    parameter logic [31:0] ADDR3    = 32'hF0000134,
    parameter int          POLL_GAP = 16
) (
    input  logic        clk,
    input  logic        reset,
    output logic        busReq,
    input  logic        busGnt,
    output logic [31:0] aBus,
    inout  wire  [31:0] dBus,
    output logic        wrtEn,
    output logic        irq,
    output logic [1:0]  irqDev,
    output logic        irqOvf,
    input  logic        irqAck
);

`ifdef IO_POLL_AUTOCLEAR_EN
    typedef enum logic [2:0] {IDLE, RD, EVAL, IRQ, WR} state_t;
`else
    typedef enum logic [2:0] {IDLE, RD, EVAL, IRQ} state_t;
`endif

    localparam logic [15:0] GAP_END  = 16'(POLL_GAP);
    localparam logic [1:0]  LAST_DEV = 2'(NDEV - 1);

    state_t      state, nextState;
    logic [1:0]  devIdx, nextIdx;
    logic [15:0] gapCnt;
    logic [31:0] ctlReg;
    logic [31:0] devAddr;
    logic        advIdx;
    logic        hit;

    assign hit     = ctlReg[0] & ctlReg[8];
    assign nextIdx = (devIdx == LAST_DEV) ? 2'd0 : devIdx + 2'd1;

    always_comb begin
        devAddr = ADDR0;
        case (devIdx)
            2'd0:    devAddr = ADDR0;
            2'd1:    devAddr = ADDR1;
            2'd2:    devAddr = ADDR2;
            default: devAddr = ADDR3;
        endcase
    end

    always_comb begin
        nextState = state;
        advIdx    = 1'b0;
        case (state)
            IDLE: if (gapCnt == GAP_END) nextState = RD;
            RD:   if (busGnt) nextState = EVAL;
            EVAL: begin
                if (hit) begin
                    nextState = IRQ;
                end else begin
                    nextState = IDLE;
                    advIdx    = 1'b1;
                end
            end
            IRQ: begin
                if (irqAck) begin
`ifdef IO_POLL_AUTOCLEAR_EN
                    nextState = WR;
`else
                    nextState = IDLE;
                    advIdx    = 1'b1;
`endif
                end
            end
`ifdef IO_POLL_AUTOCLEAR_EN
            WR: begin
                if (busGnt) begin
                    nextState = IDLE;
                    advIdx    = 1'b1;
                end
            end
`endif
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            devIdx <= 2'd0;
            gapCnt <= 16'd0;
            ctlReg <= 32'd0;
        end else begin
            state  <= nextState;
            // counter restarts on every fresh entry into IDLE
            gapCnt <= (state == IDLE && nextState == IDLE) ? gapCnt + 16'd1 : 16'd0;
            if (state == RD && busGnt) ctlReg <= dBus;
            if (advIdx) devIdx <= nextIdx;
        end
    end

`ifdef IO_POLL_AUTOCLEAR_EN
    assign busReq = (state == RD) || (state == WR);
    assign wrtEn  = (state == WR) && busGnt;
    assign dBus   = wrtEn ? {23'd0, ctlReg[8], 8'd0} : 'z;
`else
    assign busReq = (state == RD);
    assign wrtEn  = 1'b0;
    assign dBus   = 'z;
`endif

    assign aBus   = (busReq && busGnt) ? devAddr : 32'd0;
    assign irq    = (state == IRQ);
    assign irqDev = devIdx;
    assign irqOvf = irq & ctlReg[2];

    logic unusedCtl;
    assign unusedCtl = ^{ctlReg[31:9], ctlReg[7:3], ctlReg[1]};

endmodule

// File: tb/tb_io_poll_master.sv
// Bench for io_poll_master: randomized grants/acks/control words against a poll-transaction reference model.
module tb_io_poll_master;
    localparam int NDEV = 3;
    localparam int GAP  = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        busGnt = 1'b0;
    logic        irqAck = 1'b0;
    logic        busReq, wrtEn, irq, irqOvf;
    logic [1:0]  irqDev;
    logic [31:0] aBus;
    wire  [31:0] dBus;

    logic [31:0] mem [4];
    logic [31:0] rdDat;
    logic        rdEn;
    int          checks = 0;
    int          errors = 0;
    int          expDev = 0;

    always #5 clk = ~clk;

    io_poll_master #(.NDEV(NDEV), .POLL_GAP(GAP)) dut (
        .clk(clk), .reset(reset), .busReq(busReq), .busGnt(busGnt),
        .aBus(aBus), .dBus(dBus), .wrtEn(wrtEn), .irq(irq),
        .irqDev(irqDev), .irqOvf(irqOvf), .irqAck(irqAck)
    );

    function automatic logic [31:0] addrOf(int d);
        case (d)
            0:       return 32'hF0000120;
            1:       return 32'hF0000104;
            2:       return 32'hF0000114;
            default: return 32'hF0000134;
        endcase
    endfunction

    // device responder: returns the addressed control word on owned reads
    always_comb begin
        rdDat = 32'd0;
        rdEn  = 1'b0;
        for (int d = 0; d < 4; d++) begin
            if (aBus != 32'd0 && aBus == addrOf(d)) begin
                rdDat = mem[d];
                rdEn  = !wrtEn;
            end
        end
    end
    assign dBus = rdEn ? rdDat : 'z;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic afterReset();
        reset  = 1'b0;
        busGnt = 1'b1;
        #1;
        chk("rst_irq", irq, 0);
        chk("rst_req", busReq, 0);
        chk("rst_addr", aBus, 0);
        chk("rst_dev", irqDev, 0);
        chk("rst_wr", wrtEn, 0);
        expDev = 0;
    endtask

    function automatic int grantDelay();
        return ($urandom_range(0, 7) == 0) ? 10 : $urandom_range(0, 3);
    endfunction

    // One poll of device expDev starting at the first IDLE cycle.
    // rstAt: 0 none, 1 reset in the granted read cycle, 2 reset while irq is up.
    task automatic pollOnce(input int rstAt);
        logic [31:0] ctl;
        int g, a;
        for (int i = 0; i <= GAP; i++) begin
            busGnt = 1'($urandom); irqAck = 1'($urandom);
            #2;
            chk("idle_req", busReq, 0);
            chk("idle_addr", aBus, 0);
            chk("idle_irq", irq, 0);
            chk("idle_wr", wrtEn, 0);
            tick();
        end
        g = grantDelay();
        for (int i = 0; i < g; i++) begin
            busGnt = 1'b0; irqAck = 1'($urandom);
            #2;
            chk("rdwait_req", busReq, 1);
            chk("rdwait_addr", aBus, 0);
            chk("rdwait_wr", wrtEn, 0);
            tick();
        end
        busGnt = 1'b1; irqAck = 1'($urandom);
        #2;
        chk("rd_req", busReq, 1);
        chk("rd_addr", aBus, addrOf(expDev));
        chk("rd_wr", wrtEn, 0);
        ctl = mem[expDev];
        if (rstAt == 1) begin
            reset = 1'b1;
            tick();
            afterReset();
            return;
        end
        tick();
        busGnt = 1'($urandom); irqAck = 1'($urandom);
        #2;
        chk("eval_req", busReq, 0);
        chk("eval_addr", aBus, 0);
        chk("eval_irq", irq, 0);
        tick();
        if (ctl[0] && ctl[8]) begin
            a = $urandom_range(0, 3);
            for (int i = 0; i <= a; i++) begin
                busGnt = 1'($urandom); irqAck = (i == a);
                #2;
                chk("irq_lvl", irq, 1);
                chk("irq_dev", irqDev, 32'(expDev));
                chk("irq_ovf", irqOvf, ctl[2]);
                chk("irq_req", busReq, 0);
                chk("irq_addr", aBus, 0);
                if (rstAt == 2) begin
                    irqAck = 1'b0;
                    reset = 1'b1;
                    tick();
                    afterReset();
                    return;
                end
                tick();
            end
            irqAck = 1'b0;
`ifdef IO_POLL_AUTOCLEAR_EN
            g = grantDelay();
            for (int i = 0; i < g; i++) begin
                busGnt = 1'b0;
                #2;
                chk("wrwait_req", busReq, 1);
                chk("wrwait_addr", aBus, 0);
                chk("wrwait_wr", wrtEn, 0);
                chk("wrwait_irq", irq, 0);
                tick();
            end
            busGnt = 1'b1;
            #2;
            chk("wr_strobe", wrtEn, 1);
            chk("wr_addr", aBus, addrOf(expDev));
            chk("wr_data", dBus, 32'h100);
            chk("wr_irq", irq, 0);
            mem[expDev] = dBus;
            tick();
`endif
        end
        busGnt = 1'b0;
        expDev = (expDev + 1) % NDEV;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] pat [6];
        pat[0] = 32'h101; pat[1] = 32'h105; pat[2] = 32'h001;
        pat[3] = 32'h100; pat[4] = 32'h000; pat[5] = 32'h000;
        mem[0] = 32'h101; mem[1] = 32'h001; mem[2] = 32'h105; mem[3] = 32'h000;

        reset = 1'b1;
        repeat (3) tick();
        #1;
        chk("reset_req", busReq, 0);
        chk("reset_addr", aBus, 0);
        chk("reset_irq", irq, 0);
        chk("reset_dev", irqDev, 0);
        chk("reset_ovf", irqOvf, 0);
        chk("reset_wr", wrtEn, 0);
        reset = 1'b0;

        // directed: irq on timer, no irq on keys, overflow on switches, revisit timer
        repeat (4) pollOnce(0);

        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 1) == 1) begin
                pat[5] = $urandom;
                mem[expDev] = pat[$urandom_range(0, 5)];
            end
            pollOnce(0);
        end

        // reset while irq pending, then reset during an owned read
        while (expDev != 1) pollOnce(0);
        mem[1] = 32'h101;
        pollOnce(2);
        repeat (3) pollOnce(0);
        pollOnce(1);
        repeat (4) pollOnce(0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/io_poll_master.md
# io_poll_master

Bus initiator that services memory-mapped I/O devices (timer, keys, switches) by polling their control registers over the shared aBus/dBus/wrtEn bus. It reads each device's control word in round-robin order and raises an interrupt request toward the CPU when the device's ready bit (bit 0) and interrupt-enable bit (bit 8) are both set. After the CPU acknowledges, it optionally writes back to clear the device's ready and overflow bits. It sits beside the CPU as a second bus master behind the bus arbiter.

## Interface
- NDEV, 3, number of polled devices, legal range 1..4
- ADDR0, 32'hF0000120, control register address of device 0 (timer)
- ADDR1, 32'hF0000104, control register address of device 1 (keys)
- ADDR2, 32'hF0000114, control register address of device 2 (switches)
- ADDR3, 32'hF0000134, control register address of device 3
- POLL_GAP, 16, idle cycles between consecutive polls, 0..65535
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- busReq  out  1  request for bus ownership
- busGnt  in  1  arbiter grant; bus is owned in any cycle with busReq=1 and busGnt=1
- aBus  out  32  address; 0 when not owned
- dBus  inout  32  data; driven only during an owned write cycle, otherwise 'z
- wrtEn  out  1  write strobe; 1 only during an owned write cycle
- irq  out  1  interrupt request, level
- irqDev  out  2  index of the interrupting device, valid while irq=1
- irqOvf  out  1  copy of the captured control bit 2 (overflow), valid while irq=1
- irqAck  in  1  CPU acknowledge, sampled only in IRQ state

## Operation
- State register: IDLE, RD, EVAL, IRQ, WR. Additional state: devIdx (2b), gapCnt (16b), ctlReg (32b, captured word).
- IDLE: gapCnt counts up from 0. At gapCnt==POLL_GAP, go to RD. IDLE therefore lasts POLL_GAP+1 cycles.
- RD: busReq=1. In a cycle with busGnt=1: aBus=ADDR[devIdx], wrtEn=0. On that edge, capture dBus into ctlReg and go to EVAL. With busGnt=0, aBus=0 and the block stays in RD indefinitely.
- EVAL (1 cycle, no bus activity):
  - If ctlReg[0]&ctlReg[8], go to IRQ.
  - Otherwise advance devIdx and go to IDLE.
- IRQ: irq=1, irqDev=devIdx, irqOvf=ctlReg[2]. On the edge with irqAck=1, go to WR (autoclear) or IDLE with devIdx advanced (no autoclear).
- WR: busReq=1. In a cycle with busGnt=1: aBus=ADDR[devIdx], dBus={23'b0, ctlReg[8], 8'b0}, wrtEn=1. That write clears ready and overflow and preserves IE. On that edge, advance devIdx and go to IDLE.
- devIdx advance: devIdx = (devIdx==NDEV-1) ? 0 : devIdx+1.
- gapCnt clears on every entry to IDLE.
- Only one device is serviced at a time. Other devices are not polled while IRQ is pending.
- irqAck outside the IRQ state is ignored.

## Timing
- Reset values: state=IDLE, devIdx=0, gapCnt=0, ctlReg=0, busReq=0, aBus=0, wrtEn=0, dBus='z, irq=0, irqDev=0, irqOvf=0.
- Reset mid-operation, including during an owned cycle, returns the block to IDLE on the next edge. No partial write is retried.
- All outputs are registered state decodes, except aBus/dBus/wrtEn, which are gated combinationally by busGnt in RD/WR.
- Read latency: data is captured on the same edge that ends the first granted RD cycle.
- Grant-to-irq latency: 2 edges (capture edge, then the EVAL edge). irq rises in the cycle after EVAL.
- irq falls in the cycle after the acknowledging edge.
- busReq stays high through the granted cycle and drops in the following cycle.
- A granted cycle is exactly 1 cycle. Grant held longer than that is unused.
- Minimum poll period with an always-granted bus and no interrupt: POLL_GAP+3 cycles.

## Configuration
- IO_POLL_AUTOCLEAR_EN defined: IRQ→WR on ack, and the clearing write is issued as described above.
- IO_POLL_AUTOCLEAR_EN undefined: the WR state is absent. IRQ goes directly to IDLE with devIdx advanced, wrtEn is tied 0, and dBus is always 'z. Software must clear the device's ready bit itself, otherwise the device re-interrupts on its next poll.

## Test plan
- Timer responder with ctl=32'h101, busGnt=1, POLL_GAP=0 -> read at aBus=F0000120; irq=1, irqDev=0, irqOvf=0 two edges after the grant cycle. Ack -> one write cycle with dBus=32'h100, wrtEn=1. Timer ctl reads 32'h100 afterwards.
- ctl=32'h001 (IE clear) on device 0 -> no irq. Next read goes to ADDR1 after POLL_GAP+1 idle cycles.
- ctl=32'h105, then ack -> irqOvf=1 while irq=1. The write-back is 32'h100, so ready and overflow are both cleared.
- busGnt held 0 for 10 cycles in RD -> busReq=1, aBus=0, dBus='z throughout. On the first granted cycle, the read is issued and captured.
- NDEV=3, no interrupts, busGnt=1 -> read address sequence F0000120, F0000104, F0000114, F0000120, with spacing of POLL_GAP+3 cycles.
- reset asserted while irq=1 -> next cycle: irq=0, busReq=0, aBus=0, devIdx=0. Polling restarts at ADDR0 after POLL_GAP+1 cycles. Without the macro, ack -> no wrtEn pulse ever.
